// File: rtl/cart_rom_fetch.sv
// rtl/cart_rom_fetch.sv - ROM word fetcher with one-word line buffer, toggle req/ack SDRAM port, save-dirty tracking.
// Optional GB_ROM_PREFETCH_EN adds a next-word prefetch line and PREFETCH state.
module cart_rom_fetch #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 22
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_cpu,
   input  logic              cart_rd,
   input  logic              cart_wr,
   input  logic [15:0]       cart_addr,
   input  logic [9:0]        mbc_bank,
   input  logic              ram_enabled,
   input  logic              ioctl_download,
   output logic              rom_req,
   input  logic              rom_ack,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        rom_do,
   output logic              rom_busy,
   output logic              rom_err,
   output logic              sav_dirty,
   input  logic              sav_clear
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PREF} state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d, busy_q, busy_d, err_q, err_d, dirty_q, dirty_d;
   logic              valid_q, valid_d, sel_q, sel_d;
   logic [ADDR_W-1:0] addr_q, addr_d, tag_q, tag_d;
   logic [15:0]       line_q, line_d;
   logic [7:0]        do_q, do_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              rd, hit, ack_match;
   logic [ADDR_W-1:0] w_addr;

   function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

   // Next word inside the same 8 KB bank: only the 12 offset bits wrap.
   function automatic logic [ADDR_W-1:0] next_w(input logic [ADDR_W-1:0] t);
      return {t[ADDR_W-1:12], t[11:0] + 12'd1};
   endfunction

   assign rd        = ce_cpu & cart_rd & ~cart_addr[15];
   assign w_addr    = ADDR_W'({mbc_bank, cart_addr[12:1]});
   assign hit       = valid_q && (tag_q == w_addr);
   assign ack_match = (rom_ack == req_q);

`ifdef GB_ROM_PREFETCH_EN
   logic              pvalid_q, pvalid_d, pend_q, pend_d, phit;
   logic [ADDR_W-1:0] ptag_q, ptag_d, pend_addr_q, pend_addr_d;
   logic [15:0]       pline_q, pline_d;
   assign phit = pvalid_q && (ptag_q == w_addr);
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      busy_d  = busy_q;
      err_d   = err_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      line_d  = line_q;
      do_d    = do_q;
      cnt_d   = cnt_q;
`ifdef GB_ROM_PREFETCH_EN
      pvalid_d    = pvalid_q;
      pend_d      = pend_q;
      ptag_d      = ptag_q;
      pend_addr_d = pend_addr_q;
      pline_d     = pline_q;
`endif
      dirty_d = (ce_cpu & cart_wr & (cart_addr[15:13] == 3'b101) & ram_enabled)
                | (dirty_q & ~sav_clear);

      case (state_q)
         S_IDLE: begin
            if (rd) begin
               if (hit) begin
                  do_d = pick(line_q, cart_addr[0]);
`ifdef GB_ROM_PREFETCH_EN
               end else if (phit) begin
                  do_d     = pick(pline_q, cart_addr[0]);
                  line_d   = pline_q;
                  tag_d    = ptag_q;
                  valid_d  = 1'b1;
                  pvalid_d = 1'b0;
                  ptag_d   = next_w(ptag_q);
                  addr_d   = next_w(ptag_q);
                  req_d    = ~req_q;
                  cnt_d    = '0;
                  state_d  = S_PREF;
`endif
               end else begin
                  addr_d  = w_addr;
                  req_d   = ~req_q;
                  tag_d   = w_addr;
                  valid_d = 1'b0;
                  sel_d   = cart_addr[0];
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (ack_match) begin
               line_d  = rom_data;
               valid_d = 1'b1;
               do_d    = pick(rom_data, sel_q);
               busy_d  = 1'b0;
`ifdef GB_ROM_PREFETCH_EN
               pvalid_d = 1'b0;
               ptag_d   = next_w(tag_q);
               addr_d   = next_w(tag_q);
               req_d    = ~req_q;
               cnt_d    = '0;
               state_d  = S_PREF;
`else
               state_d = S_IDLE;
`endif
            end else if (cnt_q == CNT_MAX) begin
               do_d    = 8'hFF;
               err_d   = 1'b1;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef GB_ROM_PREFETCH_EN
         S_PREF: begin
            // Current-line hits are served while the prefetch is in flight; a miss waits for it.
            if (rd && hit) begin
               do_d = pick(line_q, cart_addr[0]);
            end else if (rd && !pend_q) begin
               pend_d      = 1'b1;
               pend_addr_d = w_addr;
               sel_d       = cart_addr[0];
               busy_d      = 1'b1;
            end
            if (ack_match || cnt_q == CNT_MAX) begin
               pvalid_d = ack_match;
               if (ack_match) pline_d = rom_data;
               if (pend_d) begin
                  addr_d  = pend_d && !pend_q ? w_addr : pend_addr_q;
                  tag_d   = addr_d;
                  req_d   = ~req_q;
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (ioctl_download) begin
         valid_d = 1'b0;
`ifdef GB_ROM_PREFETCH_EN
         pvalid_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         dirty_q <= 1'b0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         tag_q   <= '0;
         line_q  <= '0;
         do_q    <= 8'hFF;
         cnt_q   <= '0;
`ifdef GB_ROM_PREFETCH_EN
         pvalid_q    <= 1'b0;
         pend_q      <= 1'b0;
         ptag_q      <= '0;
         pend_addr_q <= '0;
         pline_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         dirty_q <= dirty_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
         do_q    <= do_d;
         cnt_q   <= cnt_d;
`ifdef GB_ROM_PREFETCH_EN
         pvalid_q    <= pvalid_d;
         pend_q      <= pend_d;
         ptag_q      <= ptag_d;
         pend_addr_q <= pend_addr_d;
         pline_q     <= pline_d;
`endif
      end
   end

   assign rom_req   = req_q;
   assign rom_addr  = addr_q;
   assign rom_do    = do_q;
   assign rom_busy  = busy_q;
   assign rom_err   = err_q;
   assign sav_dirty = dirty_q;
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb/tb_cart_rom_fetch.sv - directed bench with a transaction-level fetch/cache model checked every cycle.
module tb_cart_rom_fetch;
   localparam int TMO = 64;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ce_cpu = 1'b0, cart_rd = 1'b0, cart_wr = 1'b0;
   logic [15:0] cart_addr = 16'h0000;
   logic [9:0]  mbc_bank = 10'h000;
   logic        ram_enabled = 1'b0, ioctl_download = 1'b0, sav_clear = 1'b0;
   logic        rom_req, rom_ack = 1'b0;
   logic [21:0] rom_addr;
   logic [15:0] rom_data = 16'h0000;
   logic [7:0]  rom_do;
   logic        rom_busy, rom_err, sav_dirty;

   cart_rom_fetch #(.TIMEOUT_CYCLES(TMO), .ADDR_W(22)) dut (
      .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .cart_rd(cart_rd),
      .cart_wr(cart_wr), .cart_addr(cart_addr), .mbc_bank(mbc_bank),
      .ram_enabled(ram_enabled), .ioctl_download(ioctl_download),
      .rom_req(rom_req), .rom_ack(rom_ack), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_do(rom_do), .rom_busy(rom_busy),
      .rom_err(rom_err), .sav_dirty(sav_dirty), .sav_clear(sav_clear)
   );

   always #5 clk_sys = ~clk_sys;

   int n_vec = 0, n_bad = 0;

   // Expected outputs and the bench's view of the line buffer.
   logic        exp_req = 1'b0, exp_busy = 1'b0, exp_err = 1'b0, exp_dirty = 1'b0;
   logic [21:0] exp_addr = 22'h0;
   logic [7:0]  exp_do = 8'hFF;
   logic        m_valid = 1'b0;
   logic [21:0] m_tag = 22'h0;
   logic [15:0] m_line = 16'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk_sys) begin
      chk("rom_req", 32'(rom_req), 32'(exp_req));
      chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
      chk("rom_do", 32'(rom_do), 32'(exp_do));
      chk("rom_busy", 32'(rom_busy), 32'(exp_busy));
      chk("rom_err", 32'(rom_err), 32'(exp_err));
      chk("sav_dirty", 32'(sav_dirty), 32'(exp_dirty));
   end

   function automatic logic [15:0] sdram_word(input logic [21:0] a);
      if (a == 22'h003000) return 16'hBEEF;
      return a[15:0] ^ 16'hA55A;
   endfunction

   function automatic logic [7:0] byte_of(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One CPU read; on a miss the SDRAM acks ack_dly cycles after the request (never if negative).
   task automatic cpu_read(input logic [9:0] bank, input logic [15:0] a, input int ack_dly);
      logic [21:0] w;
      logic        is_hit;
      w         = {bank, a[12:1]};
      is_hit    = m_valid && (m_tag == w);
      mbc_bank  = bank;
      cart_addr = a;
      ce_cpu    = 1'b1;
      cart_rd   = 1'b1;
      tick();
      ce_cpu  = 1'b0;
      cart_rd = 1'b0;
      if (a[15]) return;
      if (is_hit) begin
         exp_do = byte_of(m_line, a[0]);
         return;
      end
      exp_req  = ~exp_req;
      exp_addr = w;
      exp_busy = 1'b1;
      m_tag    = w;
      m_valid  = 1'b0;
      if (ack_dly >= 0) begin
         repeat (ack_dly) tick();
         rom_data = sdram_word(w);
         rom_ack  = exp_req;
         tick();
         m_line   = sdram_word(w);
         m_valid  = 1'b1;
         exp_do   = byte_of(m_line, a[0]);
         exp_busy = 1'b0;
      end else begin
         repeat (TMO - 1) tick();
         tick();
         exp_do   = 8'hFF;
         exp_err  = 1'b1;
         exp_busy = 1'b0;
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic en, input logic we, input logic clr);
      cart_addr   = a;
      ram_enabled = en;
      ce_cpu      = we;
      cart_wr     = we;
      sav_clear   = clr;
      tick();
      exp_dirty   = (we && a[15:13] == 3'b101 && en) || (exp_dirty && !clr);
      ce_cpu      = 1'b0;
      cart_wr     = 1'b0;
      sav_clear   = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("reset_do", 32'(rom_do), 32'h0FF);
      chk("reset_busy_req", 32'({rom_busy, rom_req, rom_err, sav_dirty}), 32'h0);

      cpu_read(10'h003, 16'h4001, 5);
      chk("cold_addr", 32'(rom_addr), 32'h003000);
      chk("cold_req", 32'(rom_req), 32'h1);
      chk("cold_do", 32'(rom_do), 32'h0BE);

      cpu_read(10'h003, 16'h4000, 0);
      chk("hit_do", 32'(rom_do), 32'h0EF);
      chk("hit_req", 32'(rom_req), 32'h1);

      cpu_read(10'h005, 16'h4000, 2);
      chk("bank_addr", 32'(rom_addr), 32'h005000);
      chk("bank_do", 32'(rom_do), 32'h05A);

      cpu_read(10'h005, 16'hA000, 0);
      chk("ramread_do", 32'(rom_do), 32'h05A);

      cpu_read(10'h005, 16'h4100, -1);
      chk("tmo_do_err", 32'({rom_err, rom_do}), 32'h1FF);
      chk("tmo_busy", 32'(rom_busy), 32'h0);

      rom_ack = 1'b1;
      repeat (4) tick();
      cpu_read(10'h005, 16'h4002, 3);
      chk("post_tmo_req", 32'(rom_req), 32'h0);
      chk("post_tmo_do", 32'(rom_do), 32'h05B);

      cpu_read(10'h005, 16'h4003, 0);
      chk("hit_hi_do", 32'(rom_do), 32'h0F5);

      ioctl_download = 1'b1;
      tick();
      ioctl_download = 1'b0;
      m_valid = 1'b0;
      cpu_read(10'h005, 16'h4003, 1);
      chk("dl_req", 32'(rom_req), 32'h1);

      cpu_write(16'hA123, 1'b1, 1'b1, 1'b0);
      chk("dirty_set", 32'(sav_dirty), 32'h1);
      cpu_write(16'hA123, 1'b1, 1'b1, 1'b1);
      chk("dirty_set_wins", 32'(sav_dirty), 32'h1);
      cpu_write(16'hA123, 1'b1, 1'b0, 1'b1);
      chk("dirty_cleared", 32'(sav_dirty), 32'h0);
      cpu_write(16'hA123, 1'b0, 1'b1, 1'b0);
      chk("dirty_ram_off", 32'(sav_dirty), 32'h0);
      cpu_write(16'hC000, 1'b1, 1'b1, 1'b0);
      chk("dirty_c000", 32'(sav_dirty), 32'h0);
      cpu_write(16'hBFFF, 1'b1, 1'b1, 1'b0);
      chk("dirty_bfff", 32'(sav_dirty), 32'h1);

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cart_rom_fetch.md
Name: cart_rom_fetch

Overview:
- Sits directly downstream of the MBC mapper.
- Consumes the mapper's 10-bit 8 KB bank index plus CPU address, and turns ROM reads into word requests on the SDRAM port using a toggle req/ack handshake.
- Holds a one-word line buffer; stalls the CPU via `rom_busy` on a miss.
- Also tracks cart-RAM writes as a save-dirty flag for the battery-save logic.

Parameters:
- TIMEOUT_CYCLES, 64: max clk_sys cycles to wait for ack before aborting a fetch.
- ADDR_W, 22: SDRAM word-address width, equal to 10 bank bits plus 12 offset bits.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_cpu  in  1  CPU clock enable; qualifies cart_rd and cart_wr
- cart_rd  in  1  CPU read strobe
- cart_wr  in  1  CPU write strobe
- cart_addr  in  16  CPU address
- mbc_bank  in  10  mapper bank output: {16 KB bank, A13}
- ram_enabled  in  1  mapper cart-RAM enable
- ioctl_download  in  1  ROM download in progress; invalidates the line buffer
- rom_req  out  1  request toggle to SDRAM
- rom_ack  in  1  ack toggle from SDRAM; equals rom_req when data is valid
- rom_addr  out  ADDR_W  SDRAM word address
- rom_data  in  16  SDRAM word; low byte is the even address
- rom_do  out  8  byte returned to the CPU
- rom_busy  out  1  CPU stall request
- rom_err  out  1  sticky timeout flag
- sav_dirty  out  1  cart RAM modified since last clear
- sav_clear  in  1  one-cycle pulse that clears sav_dirty

Behaviour:
- Reset values: rom_req=0, rom_addr=0, rom_do=FF, rom_busy=0, rom_err=0, sav_dirty=0, line valid=0, FSM=IDLE.
- A ROM read is `ce_cpu & cart_rd & ~cart_addr[15]`.
- Word address W = {mbc_bank, cart_addr[12:1]}.
- Byte select:
  - cart_addr[0]=0 selects word[7:0].
  - cart_addr[0]=1 selects word[15:8].
- FSM states: IDLE, WAIT.
- IDLE, ROM read with hit (valid and tag==W):
  - rom_do updates on the next clk_sys edge.
  - rom_busy stays 0.
- IDLE, ROM read with miss:
  - On the same edge: rom_addr<=W, rom_req toggles, tag<=W, saved byte-select latched, rom_busy<=1, go to WAIT.
- WAIT:
  - A cycle counter starts at 0.
  - When rom_ack==rom_req: line<=rom_data, valid<=1, rom_do<=selected byte, rom_busy<=0, go to IDLE.
  - Fill-to-data latency: 1 cycle after ack matches.
- WAIT timeout: if the counter reaches TIMEOUT_CYCLES-1 without a match:
  - rom_do<=FF, rom_err<=1, valid<=0, rom_busy<=0, go to IDLE.
  - A late ack is ignored because IDLE never samples rom_ack.
  - The next miss toggles rom_req again, so the stale ack cannot be mistaken for the new one.
- CPU reads arriving while in WAIT are ignored. The CPU is stalled by rom_busy, so none are expected.
- Reads at cart_addr[15]=1 (cart RAM, VRAM) never touch rom_do or the FSM.
- ioctl_download=1:
  - Forces valid<=0 every cycle.
  - In WAIT, the FSM completes or times out normally, but the returned word is not marked valid.
- mbc_bank changes need no invalidation because the bank is part of the tag.
- Save-dirty:
  - `ce_cpu & cart_wr & cart_addr[15:13]==3'b101 & ram_enabled` sets sav_dirty.
  - sav_clear clears it.
  - If both occur in the same cycle, set wins.
  - A write with ram_enabled=0 has no effect.
- rom_err is cleared only by reset.

Optional Feature:
- Macro: GB_ROM_PREFETCH_EN.
- When defined:
  - Adds a second line buffer holding word W+1, with wrap-around inside the 8 KB bank: bits [11:0] wrap and mbc_bank is kept.
  - After any demand fill completes, the FSM enters a PREFETCH state and issues one extra request for W+1 without asserting rom_busy.
  - A CPU read during PREFETCH that hits either line is served normally.
  - A CPU read during PREFETCH that misses both lines asserts rom_busy. When the prefetch ack arrives, the prefetch line is stored and the demand miss is issued next.
  - When a demand read hits the prefetch line, it becomes the current line and a new prefetch is launched.
  - Prefetch timeout invalidates only the prefetch line and does not set rom_err.
- When undefined: single line buffer, no PREFETCH state, behaviour exactly as in Behaviour.

Test Plan:
- Cold miss: reset, then read with mbc_bank=0x003, cart_addr=0x4001.
  - Expect rom_addr=0x003000, rom_req toggles, rom_busy=1.
  - SDRAM acks after 5 cycles with data 0xBEEF; expect rom_do=0xBE one cycle after the ack matches, then rom_busy=0.
- Hit: read 0x4000 immediately after the cold miss.
  - Expect no rom_req toggle, rom_busy=0, rom_do=0xEF next edge.
- Bank change: set mbc_bank=0x005, read 0x4000.
  - Expect a miss with rom_addr=0x005000.
- Timeout: miss with no ack.
  - After 64 cycles expect rom_do=FF, rom_err=1, rom_busy=0.
  - A late ack is then ignored, and the next miss fetches correctly.
- Download invalidate: hit line present, pulse ioctl_download, re-read the same address.
  - Expect a new rom_req toggle.
- Save-dirty:
  - Write 0xA123 with ram_enabled=1: sav_dirty=1.
  - sav_clear and a write in the same cycle: sav_dirty stays 1.
  - Write with ram_enabled=0 after a clear: sav_dirty stays 0.
